// File: rtl/cond_fwd_stage.sv
// Purpose  : multi-channel conditional forwarder; each accepted word is steered
//            by in_slow through a one-entry per-channel staging register (slow
//            path) or straight into that channel's output FIFO (fast path).
//            Out-of-range channel ids are accepted, discarded and counted.
// Latency  : fast path 1 cycle, slow path 2 cycles (empty FIFO, sink ready).
// Backpres : in_ready is combinational from in_ch/in_slow/FIFO state/out_ready;
//            it never depends on in_valid. Out-of-range ids are always ready.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_ready/in_data/in_ch/in_slow    - tagged source stream
//            out_valid/out_ready/out_data               - CHANNELS sink streams,
//                                                         channel c at [c*WIDTH +: WIDTH]
//            stage_valid                                - staging register occupied
//            drop_cnt                                   - saturating dropped-word count
module cond_fwd_stage #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 3,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [CH_W-1:0]           in_ch,
    input  logic                      in_slow,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       stage_valid,
    output logic [15:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]    wr_ptr    [CHANNELS];
    logic [PW-1:0]    rd_ptr    [CHANNELS];
    logic [WIDTH-1:0] mem       [CHANNELS][DEPTH];
    logic [WIDTH-1:0] stage_dat [CHANNELS];

    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] room;
    logic [CHANNELS-1:0] drain;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] load;
    logic                ch_ok;
    logic                accept;

    // A word addresses at most one channel; no hit means an out-of-range id.
    assign ch_ok  = |hit;
    assign accept = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (hit[c]) begin
                // Fast path waits for an empty staging register so a younger
                // fast word can never overtake an older staged word.
                in_ready = in_slow ? (!stage_valid[c] || drain[c])
                                   : (!stage_valid[c] && room[c]);
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PW-1:0] cnt;

        assign hit[c]       = (in_ch == CH_W'(c));
        assign cnt          = wr_ptr[c] - rd_ptr[c];
        assign out_valid[c] = (cnt != '0);
        assign pop[c]       = out_valid[c] && out_ready[c];
        // A pop in the same cycle frees a slot, so a full FIFO still takes a push.
        assign room[c]      = (cnt != FULL_CNT) || pop[c];
        assign drain[c]     = stage_valid[c] && room[c];
        assign load[c]      = accept && hit[c] && in_slow;
        // Fast writes require an empty stage, so they never collide with drain.
        assign push[c]      = drain[c] || (accept && hit[c] && !in_slow);

        assign out_data[c*WIDTH +: WIDTH] = mem[c][rd_ptr[c][AW-1:0]];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr[c]      <= '0;
                rd_ptr[c]      <= '0;
                stage_dat[c]   <= '0;
                stage_valid[c] <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[c][i] <= '0;
                end
            end else begin
                if (push[c]) begin
                    mem[c][wr_ptr[c][AW-1:0]] <= drain[c] ? stage_dat[c] : in_data;
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
                // A load in the same cycle as a drain refills the stage.
                if (load[c]) begin
                    stage_dat[c]   <= in_data;
                    stage_valid[c] <= 1'b1;
                end else if (drain[c]) begin
                    stage_valid[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && !ch_ok && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cond_fwd_stage.sv
module tb_cond_fwd_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_ch;
    logic        in_slow;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [3:0]  stage_valid;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q [4][$];

    cond_fwd_stage #(.WIDTH(8), .CHANNELS(4), .CH_W(3), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_ch       (in_ch),
        .in_slow     (in_slow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stage_valid (stage_valid),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge record accepted words into the scoreboard
    // and compare every word the sinks take; then advance past the rising edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            if (out_valid[c] && out_ready[c]) begin
                if (exp_q[c].size() == 0) begin
                    chk($sformatf("unexpected_pop_ch%0d", c), {24'd0, out_data[c*8 +: 8]}, 32'hDEAD);
                end else begin
                    e = exp_q[c].pop_front();
                    chk($sformatf("pop_data_ch%0d", c), {24'd0, out_data[c*8 +: 8]}, {24'd0, e});
                end
            end
        end
        if (in_valid && in_ready && in_ch < 3'd4) begin
            exp_q[in_ch[1:0]].push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] ch, input logic slow, input logic [7:0] d);
        in_valid = 1'b1;
        in_ch    = ch;
        in_slow  = slow;
        in_data  = d;
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_ch    = 3'd0;
        in_slow  = 1'b0;
        in_data  = 8'h00;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 4'hF;
        idle();
        #3;
        chk("reset_out_valid",   {28'd0, out_valid},   32'h0);
        chk("reset_stage_valid", {28'd0, stage_valid}, 32'h0);
        chk("reset_out_data",    out_data,             32'h0);
        chk("reset_drop_cnt",    {16'd0, drop_cnt},    32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fast path: visible one cycle after acceptance.
        drive(3'd1, 1'b0, 8'hA5);
        chk("fast_in_ready", {31'd0, in_ready}, 32'h1);
        tick();
        idle();
        chk("fast_out_valid1", {31'd0, out_valid[1]}, 32'h1);
        chk("fast_out_data1",  {24'd0, out_data[15:8]}, 32'hA5);

        // Slow path: staged one cycle, visible after two.
        drive(3'd2, 1'b1, 8'h3C);
        chk("slow_in_ready", {31'd0, in_ready}, 32'h1);
        tick();
        idle();
        chk("slow_stage_valid2", {31'd0, stage_valid[2]}, 32'h1);
        chk("slow_out_valid2_t1", {31'd0, out_valid[2]}, 32'h0);
        tick();
        chk("slow_out_valid2_t2", {31'd0, out_valid[2]}, 32'h1);
        chk("slow_out_data2",     {24'd0, out_data[23:16]}, 32'h3C);
        chk("slow_stage_clear2",  {31'd0, stage_valid[2]}, 32'h0);
        tick();

        // Ordering: fast word blocked while an older word sits in the stage.
        drive(3'd0, 1'b1, 8'h11);
        tick();
        drive(3'd0, 1'b0, 8'h22);
        chk("order_blocked", {31'd0, in_ready}, 32'h0);
        tick();
        chk("order_unblocked", {31'd0, in_ready}, 32'h1);
        tick();
        idle();
        repeat (3) tick();
        chk("order_ch0_drained", exp_q[0].size(), 32'd0);

        // Full FIFO: fifth word waits, then enters on the same cycle as a pop.
        out_ready[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'd3, 1'b0, 8'h40 + 8'(i));
            chk($sformatf("full_fill_ready%0d", i), {31'd0, in_ready}, 32'h1);
            tick();
        end
        drive(3'd3, 1'b0, 8'h44);
        chk("full_blocked", {31'd0, in_ready}, 32'h0);
        out_ready[3] = 1'b1;
        #1;
        chk("full_push_pop_ready", {31'd0, in_ready}, 32'h1);
        tick();
        out_ready[3] = 1'b0;
        drive(3'd3, 1'b0, 8'h45);
        chk("full_count_still4", {31'd0, in_ready}, 32'h0);
        idle();
        out_ready[3] = 1'b1;
        repeat (4) tick();
        chk("full_drained_empty", {31'd0, out_valid[3]}, 32'h0);
        chk("full_ch3_queue", exp_q[3].size(), 32'd0);

        // Drops: out-of-range ids are accepted and counted, saturating.
        drive(3'd6, 1'b0, 8'h77);
        chk("drop_in_ready", {31'd0, in_ready}, 32'h1);
        tick();
        idle();
        chk("drop_cnt_one",   {16'd0, drop_cnt}, 32'h1);
        chk("drop_no_output", {28'd0, out_valid}, 32'h0);
        drive(3'd5, 1'b0, 8'h78);
        for (int i = 0; i < 65533; i++) begin
            tick();
        end
        idle();
        chk("drop_cnt_fffe", {16'd0, drop_cnt}, 32'hFFFE);
        drive(3'd7, 1'b1, 8'h79);
        repeat (3) tick();
        idle();
        chk("drop_cnt_sat", {16'd0, drop_cnt}, 32'hFFFF);

        // Asynchronous reset with words in flight.
        out_ready = 4'h0;
        for (int i = 0; i < 3; i++) begin
            drive(3'd2, 1'b0, 8'h60 + 8'(i));
            tick();
        end
        drive(3'd1, 1'b1, 8'h55);
        tick();
        idle();
        chk("pre_reset_stage1", {31'd0, stage_valid[1]}, 32'h1);
        chk("pre_reset_valid2", {31'd0, out_valid[2]},   32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid",   {28'd0, out_valid},   32'h0);
        chk("mid_reset_stage_valid", {28'd0, stage_valid}, 32'h0);
        chk("mid_reset_out_data",    out_data,             32'h0);
        chk("mid_reset_drop_cnt",    {16'd0, drop_cnt},    32'h0);
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 4'hF;
        drive(3'd1, 1'b0, 8'h99);
        tick();
        idle();
        chk("post_reset_valid1", {31'd0, out_valid[1]}, 32'h1);
        chk("post_reset_data1",  {24'd0, out_data[15:8]}, 32'h99);
        repeat (2) tick();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("final_queue_ch%0d", c), exp_q[c].size(), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
